// File: rtl/tia_pkg.sv
// Shared TIA constants: write addresses, horizontal timing and playfield
// cell index ranges.
package tia_pkg;
  localparam int H_TOTAL         = 228;
  localparam int H_VISIBLE_START = 68;
  localparam int PF_CELLS        = 20;
  localparam int H_RIGHT_START   = H_VISIBLE_START + 4 * PF_CELLS;

  localparam logic [5:0] ADDR_PF0    = 6'h0D;
  localparam logic [5:0] ADDR_PF1    = 6'h0E;
  localparam logic [5:0] ADDR_PF2    = 6'h0F;
  localparam logic [5:0] ADDR_CTRLPF = 6'h0A;

  // Token index range fed by each register (PF0 D4..D7, PF1 D7..D0, PF2 D0..D7).
  localparam int PF0_FIRST = 0;
  localparam int PF0_LAST  = 3;
  localparam int PF1_FIRST = 4;
  localparam int PF1_LAST  = 11;
  localparam int PF2_FIRST = 12;
  localparam int PF2_LAST  = 19;
endpackage

// File: rtl/tia_playfield_sequencer_if.sv
// CPU register write port into the TIA.
interface tia_playfield_sequencer_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/tia_hcounter.sv
// Horizontal colour-clock counter with line restart; exposes the next count
// so downstream registers can line up with hcount without added latency.
module tia_hcounter
  import tia_pkg::*;
#(
  parameter int H_TOTAL_P = H_TOTAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  output logic [7:0] hcount,
  output logic [7:0] next_hcount
);
  logic [7:0] hcount_q;

  always_comb begin
    if (line_start)                           next_hcount = 8'd0;
    else if (hcount_q == 8'(H_TOTAL_P - 1))   next_hcount = 8'd0;
    else                                      next_hcount = hcount_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) hcount_q <= 8'd0;
    else       hcount_q <= next_hcount;
  end

  assign hcount = hcount_q;
endmodule

// File: rtl/tia_playfield_sequencer.sv
// Playfield sequencer: PF register write decode, once-per-line reflect latch
// and one-hot token walk across the playfield cells.
module tia_playfield_sequencer
  import tia_pkg::*;
#(
  parameter int H_TOTAL_P         = H_TOTAL,
  parameter int H_VISIBLE_START_P = H_VISIBLE_START,
  parameter int PF_CELLS_P        = PF_CELLS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  tia_playfield_sequencer_if.slave cpu,
  output logic [2:0]            pf_load,
  output logic [7:0]            pf_data,
  output logic [PF_CELLS_P-1:0] pf_token,
  output logic                  pf_active,
  output logic                  pf_right,
  output logic                  reflect,
  output logic [7:0]            hcount
);
  localparam int RIGHT_START = H_VISIBLE_START_P + 4 * PF_CELLS_P;

  logic [7:0]            next_hcount;
  logic [2:0]            pf_load_q, pf_load_d;
  logic [7:0]            pf_data_q;
  logic                  reflect_q, reflect_lat_q, lat_eff;
  logic [PF_CELLS_P-1:0] token_q, token_d;
  logic                  active_q, active_d, right_q, right_d;
  logic [5:0]            pix;
  logic [4:0]            idx;

  tia_hcounter #(.H_TOTAL_P(H_TOTAL_P)) u_hcounter (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .hcount      (hcount),
    .next_hcount (next_hcount)
  );

  always_comb begin
    pf_load_d = 3'b000;
    if (cpu.wr_en) begin
      case (cpu.wr_addr)
        ADDR_PF0: pf_load_d = 3'b001;
        ADDR_PF1: pf_load_d = 3'b010;
        ADDR_PF2: pf_load_d = 3'b100;
        default:  pf_load_d = 3'b000;
      endcase
    end
  end

  // On the latch edge the token must already use the value being latched.
  always_comb begin
    active_d = (next_hcount >= 8'(H_VISIBLE_START_P));
    pix      = 6'((next_hcount - 8'(H_VISIBLE_START_P)) >> 2);
    right_d  = active_d && (pix >= 6'(PF_CELLS_P));
    lat_eff  = (next_hcount == 8'(RIGHT_START)) ? reflect_q : reflect_lat_q;
    if (!right_d)    idx = pix[4:0];
    else if (lat_eff) idx = 5'(6'(2 * PF_CELLS_P - 1) - pix);
    else              idx = 5'(pix - 6'(PF_CELLS_P));
    token_d = active_d ? ({{(PF_CELLS_P-1){1'b0}}, 1'b1} << idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_load_q     <= 3'b000;
      pf_data_q     <= 8'h00;
      reflect_q     <= 1'b0;
      reflect_lat_q <= 1'b0;
      token_q       <= '0;
      active_q      <= 1'b0;
      right_q       <= 1'b0;
    end else begin
      pf_load_q <= pf_load_d;
      if (|pf_load_d) pf_data_q <= cpu.wr_data;
      if (cpu.wr_en && cpu.wr_addr == ADDR_CTRLPF) reflect_q <= cpu.wr_data[0];
      if (next_hcount == 8'(RIGHT_START)) reflect_lat_q <= reflect_q;
      token_q  <= token_d;
      active_q <= active_d;
      right_q  <= right_d;
    end
  end

  assign pf_load   = pf_load_q;
  assign pf_data   = pf_data_q;
  assign reflect   = reflect_q;
  assign pf_token  = token_q;
  assign pf_active = active_q;
  assign pf_right  = right_q;
endmodule

// File: tb/tb_tia_playfield_sequencer.sv
// Bench for tia_playfield_sequencer: write-decode table, directed line
// sequences and random traffic against a line-level reference model.
module tb_tia_playfield_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [2:0]  pf_load;
  logic [7:0]  pf_data;
  logic [19:0] pf_token;
  logic        pf_active, pf_right, reflect;
  logic [7:0]  hcount;

  tia_playfield_sequencer_if cpu_if ();

  tia_playfield_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .cpu        (cpu_if),
    .pf_load    (pf_load),
    .pf_data    (pf_data),
    .pf_token   (pf_token),
    .pf_active  (pf_active),
    .pf_right   (pf_right),
    .reflect    (reflect),
    .hcount     (hcount)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         m_hc;
  bit         m_reflect, m_lat;
  logic [2:0] m_load;
  logic [7:0] m_data;

  function automatic logic [19:0] exp_token(int hc, bit lat);
    int p, ix;
    logic [19:0] one;
    one = 20'd1;
    if (hc < 68) return 20'd0;
    p = (hc - 68) / 4;
    if (p < 20)   ix = p;
    else if (lat) ix = 39 - p;
    else          ix = p - 20;
    return one << ix;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (hc model %0d)", name, got, exp, m_hc);
    end
  endtask

  task automatic step(input string tag, input bit r, input bit ls, input bit we,
                      input logic [5:0] a, input logic [7:0] d);
    logic [19:0] et;
    int nhc;
    reset = r; line_start = ls;
    cpu_if.wr_en = we; cpu_if.wr_addr = a; cpu_if.wr_data = d;
    @(posedge clk);
    if (r) begin
      m_hc = 0; m_reflect = 0; m_lat = 0; m_load = 3'b000; m_data = 8'h00;
    end else begin
      nhc = ls ? 0 : (m_hc + 1) % 228;
      if (nhc == 148) m_lat = m_reflect;
      m_load = 3'b000;
      if (we && a == 6'h0D) m_load = 3'b001;
      if (we && a == 6'h0E) m_load = 3'b010;
      if (we && a == 6'h0F) m_load = 3'b100;
      if (m_load != 3'b000) m_data = d;
      if (we && a == 6'h0A) m_reflect = d[0];
      m_hc = nhc;
    end
    #1;
    et = exp_token(m_hc, m_lat);
    vectors++;
    if (hcount !== 8'(m_hc) || pf_token !== et || pf_active !== (m_hc >= 68) ||
        pf_right !== (m_hc >= 148) || pf_load !== m_load || pf_data !== m_data ||
        reflect !== m_reflect) begin
      miscompares++;
      $display("FAIL %s: hcount %0d/%0d token %h/%h active %b/%b right %b/%b load %b/%b data %h/%h reflect %b/%b",
               tag, hcount, m_hc, pf_token, et, pf_active, (m_hc >= 68), pf_right, (m_hc >= 148),
               pf_load, m_load, pf_data, m_data, reflect, m_reflect);
    end
    reset = 0; line_start = 0; cpu_if.wr_en = 0;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 6'h00, 8'h00);
  endtask

  task automatic run_to(input int target, input string tag);
    int n = 0;
    while (m_hc != target && n < 300) begin
      idle(tag);
      n++;
    end
    if (m_hc != target) chk({tag, " run_to timeout"}, 32'(m_hc), 32'(target));
  endtask

  typedef struct {
    bit         r;
    bit         we;
    logic [5:0] a;
    logic [7:0] d;
    logic [2:0] e_load;
    logic [7:0] e_data;
    bit         e_refl;
  } wvec_t;

  wvec_t tbl[10];

  initial begin
    tbl[0] = '{0, 1, 6'h0D, 8'hA5, 3'b001, 8'hA5, 0};
    tbl[1] = '{0, 1, 6'h0E, 8'hA5, 3'b010, 8'hA5, 0};
    tbl[2] = '{0, 1, 6'h0F, 8'hA5, 3'b100, 8'hA5, 0};
    tbl[3] = '{0, 0, 6'h0D, 8'h00, 3'b000, 8'hA5, 0};
    tbl[4] = '{0, 1, 6'h2C, 8'h5A, 3'b000, 8'hA5, 0};
    tbl[5] = '{0, 1, 6'h0A, 8'h01, 3'b000, 8'hA5, 1};
    tbl[6] = '{0, 1, 6'h0A, 8'hFE, 3'b000, 8'hA5, 0};
    tbl[7] = '{0, 1, 6'h0D, 8'h3C, 3'b001, 8'h3C, 0};
    tbl[8] = '{0, 0, 6'h00, 8'h00, 3'b000, 8'h3C, 0};
    tbl[9] = '{1, 1, 6'h0E, 8'hFF, 3'b000, 8'h00, 0};

    reset = 1; line_start = 0;
    cpu_if.wr_en = 0; cpu_if.wr_addr = 0; cpu_if.wr_data = 0;
    m_hc = 0; m_reflect = 0; m_lat = 0; m_load = 0; m_data = 0;

    step("reset", 1, 0, 0, 6'h00, 8'h00);
    chk("reset hcount", 32'(hcount), 32'd0);
    chk("reset token", 32'(pf_token), 32'd0);

    // Free-running line with reflect off
    for (int i = 0; i < 228; i++) begin
      idle("freerun");
      case (m_hc)
        68:  chk("tok@68", 32'(pf_token), 32'h00001);
        71:  chk("tok@71", 32'(pf_token), 32'h00001);
        72:  chk("tok@72", 32'(pf_token), 32'h00002);
        147: chk("tok@147", 32'(pf_token), 32'h80000);
        148: begin
          chk("tok@148", 32'(pf_token), 32'h00001);
          chk("right@148", 32'(pf_right), 32'd1);
        end
        227: chk("tok@227", 32'(pf_token), 32'h80000);
        default: ;
      endcase
    end
    chk("wrap hcount", 32'(hcount), 32'd0);

    foreach (tbl[i]) begin
      step("table", tbl[i].r, 0, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("table[%0d] load", i), 32'(pf_load), 32'(tbl[i].e_load));
      chk($sformatf("table[%0d] data", i), 32'(pf_data), 32'(tbl[i].e_data));
      chk($sformatf("table[%0d] reflect", i), 32'(reflect), 32'(tbl[i].e_refl));
    end

    // CTRLPF=1 during HBLANK mirrors the next right half
    run_to(10, "hblank");
    step("ctrlpf set", 0, 0, 1, 6'h0A, 8'h01);
    run_to(148, "mirror");
    chk("mirror tok@148", 32'(pf_token), 32'h80000);
    run_to(227, "mirror");
    chk("mirror tok@227", 32'(pf_token), 32'h00001);

    // Toggle mid right half: current line keeps mirroring
    run_to(180, "toggle");
    step("ctrlpf clr", 0, 0, 1, 6'h0A, 8'h00);
    run_to(227, "toggle");
    chk("toggle tok@227", 32'(pf_token), 32'h00001);
    run_to(148, "toggle next");
    chk("toggle next tok@148", 32'(pf_token), 32'h00001);

    // Write on the latch edge: latch takes the old value
    run_to(147, "latch edge");
    step("ctrlpf on edge", 0, 0, 1, 6'h0A, 8'h01);
    chk("edge tok@148", 32'(pf_token), 32'h00001);
    run_to(227, "latch edge");
    chk("edge tok@227", 32'(pf_token), 32'h80000);
    run_to(148, "edge next");
    chk("edge next tok@148", 32'(pf_token), 32'h80000);

    // line_start mid-visible and coincident with wrap
    run_to(100, "ls100");
    step("ls100", 0, 1, 0, 6'h00, 8'h00);
    chk("ls100 hcount", 32'(hcount), 32'd0);
    chk("ls100 token", 32'(pf_token), 32'd0);
    run_to(227, "ls227");
    step("ls227", 0, 1, 0, 6'h00, 8'h00);
    chk("ls227 hcount", 32'(hcount), 32'd0);

    // Reset mid-line with a simultaneous PF1 write
    run_to(150, "rst150");
    step("rst150", 1, 0, 1, 6'h0E, 8'hA5);
    chk("rst150 load", 32'(pf_load), 32'd0);
    chk("rst150 token", 32'(pf_token), 32'd0);
    chk("rst150 hcount", 32'(hcount), 32'd0);
    chk("rst150 reflect", 32'(reflect), 32'd0);
    idle("rst150 after");
    chk("rst150 no pulse", 32'(pf_load), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] a;
      case ($urandom_range(0, 4))
        0: a = 6'h0D;
        1: a = 6'h0E;
        2: a = 6'h0F;
        3: a = 6'h0A;
        default: a = 6'($urandom);
      endcase
      step("random", $urandom_range(0, 499) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 3) == 0, a, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tia_playfield_sequencer.md
# tia_playfield_sequencer

Drives the 20-cell playfield register chain from the horizontal side. It does three jobs:
- decodes CPU writes to PF0/PF1/PF2/CTRLPF into per-register load strobes;
- tracks the 228-colour-clock horizontal position;
- walks a one-hot shift token across the 20 cells, forward on the left half and forward or mirrored on the right half.

Each playfield cell ANDs its latched bit with its token bit. The OR of all cells is the playfield serial output.

## Interface
Parameters:
- `H_TOTAL`, 228: colour clocks per line.
- `H_VISIBLE_START`, 68: first visible colour clock (end of HBLANK).
- `PF_CELLS`, 20: cells per half line.

Ports:
- `clk` in 1: colour clock, the single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `line_start` in 1: one-cycle pulse that forces the horizontal count to 0 (RSYNC / line restart).
- `wr_en` in 1: CPU register write strobe, one cycle.
- `wr_addr` in 6: TIA write address.
- `wr_data` in 8: write data.
- `pf_load` out 3: one-cycle load strobes. Bit 0 = PF0, bit 1 = PF1, bit 2 = PF2.
- `pf_data` out 8: registered copy of `wr_data`, valid while any `pf_load` bit is set.
- `pf_token` out 20: one-hot cell select. All zero when not visible.
- `pf_active` out 1: high during visible colour clocks.
- `pf_right` out 1: high during the right half of the visible line.
- `reflect` out 1: current CTRLPF D0 register value.
- `hcount` out 8: current horizontal count, 0..227.

## Operation
- **Register decode:** on `wr_en`, `wr_addr` selects the action.
  - 0x0D asserts `pf_load[0]`.
  - 0x0E asserts `pf_load[1]`.
  - 0x0F asserts `pf_load[2]`.
  - 0x0A writes `reflect_reg` <= `wr_data[0]`.
  - All other addresses are ignored.
- **Load strobe timing:** `pf_load` is a registered pulse lasting exactly one cycle. `pf_data` is updated in the same cycle. Back-to-back writes produce back-to-back pulses.
- **Cell order, token index 0..19:**
  - 0..3: PF0 D4..D7.
  - 4..11: PF1 D7..D0.
  - 12..19: PF2 D0..D7.
- **Bit routing:** routing `pf_data` bits to cells is the cell array's job, not this block's.
- **Horizontal counter:** `hcount` increments by one per clock. It wraps from 227 to 0.
- **Counter clear:** `line_start` forces `next_hcount` to 0. This takes priority over the increment.
- **Pixel index:** for visible positions, p = (hcount − 68) >> 2, giving 0..39, 4 colour clocks per playfield pixel.
- **Token index:**
  - p < 20 gives token index p.
  - p ≥ 20 with `reflect_lat` = 0 gives index p − 20.
  - p ≥ 20 with `reflect_lat` = 1 gives index 39 − p.
- **Reflect sampling:** `reflect_lat` samples `reflect_reg` once per line, on the edge where `next_hcount` = 148. Mid-right-half CTRLPF writes therefore do not alter the current line.
- **Output derivation:** `pf_token`, `pf_active` and `pf_right` are registered, computed from `next_hcount`. They always describe the `hcount` value present in the same cycle.
- **States:** two, HBLANK (hcount < 68) and VISIBLE. The transitions are implied by the counter; no separate FSM register is needed.

## Timing
- **Reset values:** `hcount` = 0, `pf_token` = 0, `pf_active` = 0, `pf_right` = 0, `pf_load` = 0, `pf_data` = 0, `reflect` = 0, `reflect_lat` = 0.
- **Write latency:** a `wr_en` cycle at edge N gives `pf_load` high during cycle N+1 only. `reflect` changes at edge N.
- **Token latency:** zero relative to `hcount`. On the cycle `hcount` = 68, `pf_token` = 0x00001. On `hcount` = 147, `pf_token` = 0x80000.
- **`line_start` during VISIBLE:** the next cycle has `hcount` = 0 and `pf_token` = 0.
- **`line_start` coinciding with the wrap:** the result is identical to a normal wrap, with `hcount` = 0.
- **CTRLPF write on the reflect-latch edge:** the latch takes the pre-write value. The new value applies from the next line.
- **`reset` asserted mid-line:** everything returns to reset values on that edge.
- **`reset` and `wr_en` in the same cycle:** `reset` wins; no `pf_load` pulse is produced.

## Structure
- **Shared package (`tia_pkg`):**
  - address constants PF0/PF1/PF2/CTRLPF;
  - `H_TOTAL` and `H_VISIBLE_START`;
  - the cell index ranges per register.
- **Sub-module `tia_hcounter`:** holds the 0..227 counter with `line_start` clear and provides `next_hcount`. It is reusable by the player and missile position logic.
- **Top level:** register decode, reflect latch, and token generation.

## Test plan
- **Reset, then free-run 228 clocks:**
  - `hcount` counts 0..227 then 0.
  - `pf_active` is high exactly on 68..227.
  - `pf_token` = 0 on 0..67.
- **Reflect = 0 line:**
  - `hcount` 68..71 gives token 0x00001.
  - 72 gives 0x00002.
  - 147 gives 0x80000.
  - 148 gives 0x00001, with `pf_right` = 1.
  - 227 gives 0x80000.
- **CTRLPF = 0x01 written during HBLANK:** on the next right half, `hcount` 148 gives 0x80000 and 227 gives 0x00001.
- **CTRLPF toggled at `hcount` 180:** the remainder of the line keeps the old direction; the next line uses the new one.
- **Writes of 0x0D/0x0E/0x0F, data 0xA5:**
  - `pf_load` = 001, 010, 100 respectively, each for one cycle.
  - `pf_data` = 0xA5.
  - A write to 0x2C gives no pulse.
- **Edge cases:**
  - `line_start` at `hcount` 100 gives `hcount` 0 and token 0 the next cycle.
  - `reset` at `hcount` 150 with a simultaneous PF1 write gives all outputs 0 and no pulse.
